// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: buffer state, the
// buffered register-write entry and the result-select helper.
package wb_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int CNT_W  = 16;

    // r0 is hardwired to zero in the register bank
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Link has priority over MemToReg
    function automatic logic [DATA_W-1:0] wb_select(
        input logic              link,
        input logic              mem_to_reg,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] load,
        input logic [DATA_W-1:0] pc4
    );
        return link ? pc4 : (mem_to_reg ? load : alu);
    endfunction

endpackage

// File: rtl/wb_if.sv
// MEM -> WB handshake and payload; master is the MEM stage, slave is wb_stage.
interface wb_if;
    import wb_pkg::*;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_RegWrite;
    logic              mem_MemToReg;
    logic              mem_Link;
    logic [REG_AW-1:0] mem_writeRegister;
    logic [DATA_W-1:0] mem_aluResult;
    logic [DATA_W-1:0] mem_readData;
    logic [DATA_W-1:0] mem_PC4;

    modport master (
        output mem_valid, mem_RegWrite, mem_MemToReg, mem_Link,
               mem_writeRegister, mem_aluResult, mem_readData, mem_PC4,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_RegWrite, mem_MemToReg, mem_Link,
               mem_writeRegister, mem_aluResult, mem_readData, mem_PC4,
        output mem_ready
    );

endinterface

// File: rtl/wb_skid_buffer.sv
// Two-entry skid buffer (head + skid) with a registered ready, so the
// upstream ready never depends combinationally on the downstream stall.
module wb_skid_buffer
    import wb_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   in_valid_i,
    output logic   in_ready_o,
    input  entry_t in_entry_i,
    input  logic   commit_i,
    output logic   head_valid_o,
    output entry_t head_o
);

    state_t state_q;
    entry_t head_q;
    entry_t skid_q;
    logic   ready_q;
    logic   accept;

    assign accept = in_valid_i & ready_q;

    // NOTE: all state below uses non-blocking assignments so every branch
    // sees the pre-edge values; the two entries are reset so a reset
    // mid-stream can never leak a stale write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q  <= in_entry_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (commit_i && accept) begin
                        head_q <= in_entry_i;
                    end else if (commit_i) begin
                        state_q <= EMPTY;
                    end else if (accept) begin
                        skid_q  <= in_entry_i;
                        state_q <= TWO;
                        ready_q <= 1'b0;
                    end
                end
                TWO: begin
                    // ready_q is low here, so nothing can be accepted
                    if (commit_i) begin
                        head_q  <= skid_q;
                        state_q <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o   = ready_q;
    assign head_valid_o = (state_q != EMPTY);
    assign head_o       = head_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, r0 write suppression, retired counter and
// optional decode bypass (enabled by defining WB_FORWARD_EN).
module wb_stage
    import wb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    wb_if.slave               mem,
    input  logic              wb_stall,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              RegWrite,
    output logic [REG_AW-1:0] writeRegister,
    output logic [DATA_W-1:0] writeDat,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired
);

    entry_t           in_entry;
    entry_t           head;
    logic             head_valid;
    logic             commit;
    logic [CNT_W-1:0] retired_q;

    always_comb begin
        in_entry.we   = mem.mem_RegWrite & (mem.mem_writeRegister != REG_ZERO);
        in_entry.rd   = mem.mem_writeRegister;
        in_entry.data = wb_select(mem.mem_Link, mem.mem_MemToReg, mem.mem_aluResult,
                                  mem.mem_readData, mem.mem_PC4);
    end

    wb_skid_buffer u_buf (
        .clock        (clock),
        .reset        (reset),
        .in_valid_i   (mem.mem_valid),
        .in_ready_o   (mem.mem_ready),
        .in_entry_i   (in_entry),
        .commit_i     (commit),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    assign commit        = head_valid & ~wb_stall;
    assign RegWrite      = commit & head.we;
    assign writeRegister = head_valid ? head.rd   : '0;
    assign writeDat      = head_valid ? head.data : '0;

    // r0-suppressed instructions still retire
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (commit) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;

`ifdef WB_FORWARD_EN
    // Only the head is forwarded; the younger skid entry is covered by the decode interlock
    assign fwd_hit1 = head_valid & head.we & (id_rs == head.rd);
    assign fwd_hit2 = head_valid & head.we & (id_rt == head.rd);
    assign fwd_data = head.data;
`else
    logic unused_id;
    assign unused_id = ^{id_rs, id_rt};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data  = '0;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 16-bit pipelined processor: accepts completed instructions from the MEM stage over a valid/ready handshake, selects the result (ALU, load data or link PC4), and drives the register bank write port (RegWrite, writeRegister, writeDat) that the decode stage's bank consumes. A two-entry skid buffer absorbs write-port stalls without combinational ready paths. A retired-instruction counter and optional decode-stage bypass are included.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 3, register address width
- CNT_W, 16, retired counter width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- mem_valid  in  1  MEM offers an instruction
- mem_ready  out  1  stage can accept (registered)
- mem_RegWrite  in  1  instruction writes a register
- mem_MemToReg  in  1  select load data
- mem_Link  in  1  select PC4 (jump-and-link); overrides MemToReg
- mem_writeRegister  in  REG_AW  destination register
- mem_aluResult  in  DATA_W  ALU result
- mem_readData  in  DATA_W  load data
- mem_PC4  in  DATA_W  return address
- wb_stall  in  1  bank write port unavailable this cycle
- id_rs, id_rt  in  REG_AW  decode-stage read addresses
- RegWrite  out  1  bank write enable
- writeRegister  out  REG_AW  bank write address
- writeDat  out  DATA_W  bank write data
- fwd_hit1, fwd_hit2  out  1  bypass valid for id_rs / id_rt
- fwd_data  out  DATA_W  bypass value
- retired  out  CNT_W  committed-instruction count

## Operation
- Accept = mem_valid & mem_ready. On accept, result mux evaluated and stored: Link ? PC4 : MemToReg ? readData : aluResult; entry = {we, reg, data}.
- Entry we cleared at accept when mem_writeRegister == 0 (r0 hardwired zero); instruction still retires.
- Commit = head valid & ~wb_stall. RegWrite = head valid & head.we & ~wb_stall; writeRegister/writeDat = head fields (zero when head empty).
- States: EMPTY, ONE (head), TWO (head+skid).
  - EMPTY: accept -> ONE.
  - ONE: commit&accept -> ONE (new head); commit -> EMPTY; accept -> TWO; else hold.
  - TWO: no accept possible; commit -> ONE (skid becomes head); else hold.
- mem_ready flop = next state != TWO.
- retired increments by 1 per commit; wraps 2^CNT_W-1 -> 0.
- Bypass: fwd_hitN = head valid & head.we & (id_rX == head.reg); fwd_data = head.data. Skid entry never forwarded (younger than head; decode interlock covers it).

## Timing
- Reset: state EMPTY, mem_ready=1, RegWrite=0, writeRegister=0, writeDat=0, fwd_hit*=0, fwd_data=0, retired=0.
- Latency: accept at edge N -> RegWrite high during cycle N+1 if wb_stall=0.
- Throughput one instruction/cycle with wb_stall low.
- wb_stall high holds head outputs stable, RegWrite low; at most one more accept (into skid), then mem_ready low next cycle.
- Commit and accept same edge in ONE: no bubble; counter increments once.
- Reset mid-operation: buffered entries discarded, no write issued, counter cleared.
- mem_valid while mem_ready low: ignored; MEM must hold payload.

## Configuration
- WB_FORWARD_EN defined: bypass logic as above.
- Undefined: fwd_hit1, fwd_hit2, fwd_data tied 0; ports retained; no compare logic.

## Structure
- Package wb_pkg: state enum (EMPTY/ONE/TWO), REG_ZERO constant, entry struct {we, reg, data}.
- Sub-module wb_skid_buffer: two-entry buffer with registered ready; wb_stage adds result mux, r0 suppression, counter, bypass.

## Test plan
- Reset, single ALU write r3=0x1234 -> RegWrite high one cycle after accept, writeRegister=3, writeDat=0x1234, retired=1.
- Back-to-back load (MemToReg, data 0xBEEF to r5) then link (PC4 0x0042 to r7) -> consecutive writes, no bubble, retired=2.
- wb_stall held 3 cycles with continuous mem_valid -> exactly one skid accept, mem_ready low, writes resume in order after release, none lost or duplicated.
- Write to r0 with aluResult 0xFFFF -> RegWrite stays 0, retired increments.
- WB_FORWARD_EN, head writing r2=0x00AA, id_rs=2, id_rt=4 -> fwd_hit1=1, fwd_hit2=0, fwd_data=0x00AA.
- Preload retired 0xFFFF via 65535 commits, one more commit -> 0x0000; reset asserted with TWO state -> all outputs to reset values immediately.
